vram_arbiter: RTL

Time-slot arbiter sharing the single-port VRAM SRAM between the pixel GPU and the CPU/loader port. Runs on the 100 MHz memory clock and divides each 25 MHz pixel period into four slots. Two slots serve the GPU's sprite-then-background read with transparency fallback; two serve CPU read/write requests. Sits between the GPU, the CPU bus bridge and the SRAM pin driver.

---
 rtl/vram_pkg.sv | 21 ++
 rtl/vram_slot_gen.sv | 47 ++++
 rtl/vram_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vram_pkg : shared slot encoding and sizing for the VRAM arbiter       |
// | Rev 1.0  : initial release                                            |
// +-----------------------------------------------------------------------+
package vram_pkg;

    localparam int SLOTS_PER_PIXEL = 4;
    localparam int VRAM_ADDR_W     = 20;
    localparam int VRAM_DATA_W     = 8;

    typedef enum logic [2:0] {
        SLOT_IDLE  = 3'd0,
        SLOT_GPU_A = 3'd1,
        SLOT_GPU_B = 3'd2,
        SLOT_CPU0  = 3'd3,
        SLOT_CPU1  = 3'd4
    } slot_e;

endpackage
`default_nettype wire

// File: rtl/vram_slot_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vram_slot_gen : four-slot phase sequencer restarted by pixel_tick     |
// | Rev 1.0       : initial release                                       |
// +-----------------------------------------------------------------------+
module vram_slot_gen
    import vram_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  pixel_tick,
    output slot_e slot
);

    slot_e slot_q;
    slot_e slot_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= SLOT_IDLE;
        end else begin
            slot_q <= slot_d;
        end
    end

    // A tick always restarts the pixel, even in the middle of one.
    always_comb begin
        slot_d = slot_q;
        if (pixel_tick) begin
            slot_d = SLOT_GPU_A;
        end else begin
            case (slot_q)
                SLOT_GPU_A: slot_d = SLOT_GPU_B;
                SLOT_GPU_B: slot_d = SLOT_CPU0;
                SLOT_CPU0:  slot_d = SLOT_CPU1;
                SLOT_CPU1:  slot_d = SLOT_IDLE;
                default:    slot_d = SLOT_IDLE;
            endcase
        end
    end

    always_comb begin
        slot = slot_q;
    end

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vram_arbiter : time-slot VRAM sharing between pixel GPU and CPU port  |
// | Option       : VRAM_SLOT_RECLAIM_EN lends an unused GPU_B slot to CPU |
// | Rev 1.0      : initial release                                        |
// +-----------------------------------------------------------------------+
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pixel_tick,
    input  logic              gpu_sprite_hit,
    input  logic [ADDR_W-1:0] gpu_sprite_addr,
    input  logic [ADDR_W-1:0] gpu_bg_addr,
    input  logic [DATA_W-1:0] sprite_transparent,
    output logic [DATA_W-1:0] gpu_pixel,
    output logic              gpu_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_oe,
    output logic              sram_we
);

    slot_e slot;

    logic [DATA_W-1:0] ra_q, ra_d;
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              w_need_bg;
    logic              w_cpu_slot;

    vram_slot_gen u_slot_gen (
        .clk        (clk),
        .rst        (rst),
        .pixel_tick (pixel_tick),
        .slot       (slot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ra_q    <= '0;
            hit_q   <= 1'b0;
            pend_q  <= '0;
            pix_q   <= '0;
            rdata_q <= '0;
        end else begin
            ra_q    <= ra_d;
            hit_q   <= hit_d;
            pend_q  <= pend_d;
            pix_q   <= pix_d;
            rdata_q <= rdata_d;
        end
    end

    assign w_need_bg = hit_q && (ra_q == sprite_transparent);
    assign cpu_rdata = rdata_q;

    // Slot outputs are combinational and forced quiet while reset is held.
    always_comb begin
        ra_d       = ra_q;
        hit_d      = hit_q;
        pend_d     = pend_q;
        pix_d      = pix_q;
        rdata_d    = rdata_q;
        w_cpu_slot = 1'b0;
        gpu_pixel  = pix_q;
        gpu_valid  = 1'b0;
        cpu_ack    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_oe    = 1'b0;
        sram_we    = 1'b0;
        if (!rst) begin
            case (slot)
                SLOT_GPU_A: begin
                    sram_oe   = 1'b1;
                    sram_addr = gpu_sprite_hit ? gpu_sprite_addr : gpu_bg_addr;
                    ra_d      = sram_rdata;
                    hit_d     = gpu_sprite_hit;
                end
                SLOT_GPU_B: begin
                    if (w_need_bg) begin
                        sram_oe   = 1'b1;
                        sram_addr = gpu_bg_addr;
                        pend_d    = sram_rdata;
                    end else begin
                        pend_d = ra_q;
`ifdef VRAM_SLOT_RECLAIM_EN
                        w_cpu_slot = 1'b1;
`endif
                    end
                end
                SLOT_CPU0: begin
                    w_cpu_slot = 1'b1;
                    // A tick landing here abandons the pixel without publishing it.
                    if (!pixel_tick) begin
                        gpu_valid = 1'b1;
                        gpu_pixel = pend_q;
                        pix_d     = pend_q;
                    end
                end
                default: begin
                    w_cpu_slot = 1'b1;
                end
            endcase
            if (w_cpu_slot && cpu_req) begin
                cpu_ack   = 1'b1;
                sram_addr = cpu_addr;
                if (cpu_we) begin
                    sram_we    = 1'b1;
                    sram_wdata = cpu_wdata;
                end else begin
                    sram_oe = 1'b1;
                    rdata_d = sram_rdata;
                end
            end
        end
    end

endmodule
`default_nettype wire
